// File: rtl/ep_cmd_sequencer.sv
// ep_cmd_sequencer
//   Host-driven command sequencer for the FrontPanel endpoint datapath.
//   A trigger-in pulse captures an opcode and two 16-bit operands. The command
//   runs on one shared arithmetic datapath: ADD, SUB, NOP and ACC take a single
//   EXEC cycle, and MUL is a 16-cycle shift-add. The block then posts a 32-bit
//   result and a status word for the host to poll.
//
// Ports
//   ti_clk      host-interface clock, rising edge
//   reset       asynchronous active-high reset
//   cmd_trig    one-cycle start pulse; cmd_op/op_a/op_b are sampled with it
//   cmd_op      3-bit opcode (0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 ACC, 5..7 illegal)
//   op_a, op_b  16-bit operands
//   cmd_ack     one-cycle pulse; clears the done, overrun and illegal flags
//   result_lo   result[15:0]
//   result_hi   result[31:16]
//   status      {cmd_count[7:0], last_op[3:0], illegal, overrun, done, busy}
//   done_pulse  one-cycle completion pulse
module ep_cmd_sequencer #(
  parameter int CNT_W  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic        ti_clk,
  input  logic        reset,
  input  logic        cmd_trig,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        cmd_ack,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi,
  output logic [15:0] status,
  output logic        done_pulse
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_ACC = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, MULT, DONE} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q;
  logic [CNT_W-1:0] cmd_cnt_q;
  logic [3:0]       last_op_q;
  logic [31:0]      res_q;   // staged result, published on the DONE edge
  logic [31:0]      acc_q;
  logic [31:0]      prod_q;
  logic [3:0]       it_cnt_q;
  logic             busy_q, done_q, overrun_q, illegal_q;

  // control strobes decoded from the state
  logic accept, drop, exec, mul_step, mul_last, finish, ill_hit;

  logic        op_illegal;
  logic [16:0] add_sum;
  logic [31:0] acc_sum;
  logic [3:0]  bit_idx;
  logic [31:0] prod_next;
  logic [7:0]  cnt8;

  assign op_illegal = (cmd_q.op > OP_ACC) || ((cmd_q.op == OP_MUL) && !MUL_EN);
  assign add_sum    = {1'b0, cmd_q.a} + {1'b0, cmd_q.b};
  assign acc_sum    = acc_q + {16'h0000, cmd_q.a};

  // The counter is loaded with 15 and counts down, so the operand bit under
  // test runs from 0 up to 15.
  assign bit_idx   = 4'd15 - it_cnt_q;
  assign prod_next = prod_q + (cmd_q.b[bit_idx] ? ({16'h0000, cmd_q.a} << bit_idx) : 32'h0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_trig) state_d = EXEC;
      EXEC: state_d = ((cmd_q.op == OP_MUL) && !op_illegal) ? MULT : DONE;
      MULT: if (it_cnt_q == 4'd0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs (control strobes) ----------------
  always_comb begin
    accept   = (state_q == IDLE) && cmd_trig;
    drop     = (state_q != IDLE) && cmd_trig;
    exec     = (state_q == EXEC);
    ill_hit  = exec && op_illegal;
    mul_step = (state_q == MULT);
    mul_last = mul_step && (it_cnt_q == 4'd0);
    finish   = (state_q == DONE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      cmd_q      <= '0;
      cmd_cnt_q  <= '0;
      last_op_q  <= '0;
      res_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      it_cnt_q   <= '0;
      result_lo  <= '0;
      result_hi  <= '0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= finish;
      if (accept) begin
        cmd_q     <= '{op: cmd_op, a: op_a, b: op_b};
        cmd_cnt_q <= cmd_cnt_q + 1'b1;
        last_op_q <= {1'b0, cmd_op};
      end
      if (exec && !op_illegal) begin
        case (cmd_q.op)
          OP_ADD: res_q <= {15'h0000, add_sum};
          OP_SUB: res_q <= {(cmd_q.a < cmd_q.b) ? 16'hFFFF : 16'h0000, cmd_q.a - cmd_q.b};
          OP_MUL: begin
            prod_q   <= '0;
            it_cnt_q <= 4'd15;
          end
          OP_ACC: begin
            acc_q <= acc_sum;
            res_q <= acc_sum;
          end
          default: ;  // NOP leaves the result untouched
        endcase
      end
      if (mul_step) begin
        prod_q   <= prod_next;
        it_cnt_q <= it_cnt_q - 1'b1;
        if (mul_last) res_q <= prod_next;
      end
      if (finish) begin
        result_lo <= res_q[15:0];
        result_hi <= res_q[31:16];
      end
    end
  end

  // ---------------- host-visible flags ----------------
  // A raised flag takes priority over cmd_ack in the same cycle.
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept)      busy_q <= 1'b1;
      else if (finish) busy_q <= 1'b0;

      if (finish)                 done_q <= 1'b1;
      else if (accept || cmd_ack) done_q <= 1'b0;

      if (drop)         overrun_q <= 1'b1;
      else if (cmd_ack) overrun_q <= 1'b0;

      if (ill_hit)      illegal_q <= 1'b1;
      else if (cmd_ack) illegal_q <= 1'b0;
    end
  end

  // Every status field comes straight from a flop. When CNT_W < 8 the count
  // is zero-extended.
  always_comb begin
    cnt8 = '0;
    cnt8[CNT_W-1:0] = cmd_cnt_q;
    status = {cnt8, last_op_q, illegal_q, overrun_q, done_q, busy_q};
  end

endmodule

// File: tb/tb_ep_cmd_sequencer.sv
module tb_ep_cmd_sequencer;

  logic        ti_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        cmd_trig = 1'b0, trig0 = 1'b0, cmd_ack = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [15:0] op_a = '0, op_b = '0;
  logic [15:0] result_lo, result_hi, status;
  logic        done_pulse;
  logic [15:0] r0_lo, r0_hi, st0;
  logic        dp0;

  always #5 ti_clk = ~ti_clk;

  int cyc = 0;
  always @(posedge ti_clk) cyc <= cyc + 1;

  ep_cmd_sequencer #(.CNT_W(8), .MUL_EN(1'b1)) u_dut (
    .ti_clk(ti_clk), .reset(reset), .cmd_trig(cmd_trig), .cmd_op(cmd_op),
    .op_a(op_a), .op_b(op_b), .cmd_ack(cmd_ack), .result_lo(result_lo),
    .result_hi(result_hi), .status(status), .done_pulse(done_pulse));

  // MUL disabled: opcode 3 must be flagged illegal
  ep_cmd_sequencer #(.CNT_W(8), .MUL_EN(1'b0)) u_dut0 (
    .ti_clk(ti_clk), .reset(reset), .cmd_trig(trig0), .cmd_op(cmd_op),
    .op_a(op_a), .op_b(op_b), .cmd_ack(cmd_ack), .result_lo(r0_lo),
    .result_hi(r0_hi), .status(st0), .done_pulse(dp0));

  typedef struct {
    logic [31:0] res;
    logic [15:0] st;
    int          t0;
    int          lat;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t m0_e, m1_e;
  int   n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: each completion pops one expected response.
  always @(negedge ti_clk) begin
    if (done_pulse) begin
      if (q0.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_done: done_pulse=1 with no command pending (t=%0t)", $time);
      end else begin
        m0_e = q0.pop_front();
        chk("result", {result_hi, result_lo}, m0_e.res);
        chk("status", {16'h0000, status}, {16'h0000, m0_e.st});
        chk("latency", 32'(cyc - m0_e.t0), 32'(m0_e.lat));
      end
    end
  end

  always @(negedge ti_clk) begin
    if (dp0) begin
      if (q1.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_done0: done_pulse=1 with no command pending (t=%0t)", $time);
      end else begin
        m1_e = q1.pop_front();
        chk("result0", {r0_hi, r0_lo}, m1_e.res);
        chk("status0", {16'h0000, st0}, {16'h0000, m1_e.st});
        chk("latency0", 32'(cyc - m1_e.t0), 32'(m1_e.lat));
      end
    end
  end

  // Drive one trigger. The expected response is queued keyed on the edge
  // that sampled the trigger.
  task automatic issue(input bit which, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit want, input logic [31:0] er,
                       input logic [15:0] es, input int lat);
    exp_t e;
    @(negedge ti_clk);
    cmd_op = op; op_a = a; op_b = b;
    if (which) trig0 = 1'b1; else cmd_trig = 1'b1;
    @(posedge ti_clk); #1;
    cmd_trig = 1'b0; trig0 = 1'b0;
    if (want) begin
      e.res = er; e.st = es; e.t0 = cyc; e.lat = lat;
      if (which) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic ack();
    @(negedge ti_clk); cmd_ack = 1'b1;
    @(posedge ti_clk); #1; cmd_ack = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_status"}, {16'h0000, status}, 32'h0);
    chk({nm, "_result"}, {result_hi, result_lo}, 32'h0);
    chk({nm, "_done_pulse"}, {31'h0, done_pulse}, 32'h0);
  endtask

  initial begin
    #12;
    check_zero("reset");
    @(negedge ti_clk); reset = 1'b0;

    // ADD with carry into bit 16
    issue(0, 3'd1, 16'hFFFF, 16'h0001, 1, 32'h0001_0000, 16'h0112, 2);
    repeat (3) @(posedge ti_clk);
    // SUB with borrow
    issue(0, 3'd2, 16'd3, 16'd5, 1, 32'hFFFF_FFFE, 16'h0222, 2);
    repeat (3) @(posedge ti_clk);
    // MUL full-scale
    issue(0, 3'd3, 16'hFFFF, 16'hFFFF, 1, 32'hFFFE_0001, 16'h0332, 18);
    repeat (20) @(posedge ti_clk);

    // MUL by zero, with a second trigger 4 cycles later that must be dropped
    issue(0, 3'd3, 16'd1234, 16'd0, 1, 32'h0000_0000, 16'h0436, 18);
    repeat (3) @(posedge ti_clk);
    issue(0, 3'd1, 16'd7, 16'd7, 0, 32'h0, 16'h0, 0);
    chk("overrun_busy", {16'h0000, status}, 32'h0000_0435);
    repeat (18) @(posedge ti_clk);
    ack();
    chk("ack_clears", {16'h0000, status}, 32'h0000_0430);

    // accumulator
    issue(0, 3'd4, 16'h8000, 16'h0, 1, 32'h0000_8000, 16'h0542, 2);
    repeat (3) @(posedge ti_clk);
    issue(0, 3'd4, 16'h8000, 16'h0, 1, 32'h0001_0000, 16'h0642, 2);
    repeat (3) @(posedge ti_clk);
    issue(0, 3'd4, 16'h8000, 16'h0, 1, 32'h0001_8000, 16'h0742, 2);
    repeat (3) @(posedge ti_clk);

    // reset clears the accumulator and status
    #2 reset = 1'b1;
    #1 check_zero("reset2");
    @(negedge ti_clk); reset = 1'b0;
    issue(0, 3'd4, 16'h8000, 16'h0, 1, 32'h0000_8000, 16'h0142, 2);
    repeat (3) @(posedge ti_clk);

    // illegal opcode: counted, result unchanged, still completes
    issue(0, 3'd6, 16'd1, 16'd1, 1, 32'h0000_8000, 16'h026A, 2);
    repeat (3) @(posedge ti_clk);
    ack();
    chk("ack_illegal", {16'h0000, status}, 32'h0000_0260);

    // MUL_EN=0 instance: opcode 3 is illegal
    issue(1, 3'd3, 16'd5, 16'd7, 1, 32'h0000_0000, 16'h013A, 2);
    repeat (4) @(posedge ti_clk);

    // reset mid-MULT aborts without done_pulse
    issue(0, 3'd3, 16'd3, 16'd5, 0, 32'h0, 16'h0, 0);
    repeat (8) @(posedge ti_clk);
    #2 reset = 1'b1;
    #1 check_zero("abort");
    @(posedge ti_clk);
    @(negedge ti_clk); reset = 1'b0;
    issue(0, 3'd1, 16'd2, 16'd3, 1, 32'h0000_0005, 16'h0112, 2);

    for (int i = 0; i < 40 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge ti_clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL drain: %0d/%0d responses never arrived, required 0", q0.size(), q1.size());
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ep_cmd_sequencer.md
Name: ep_cmd_sequencer

Overview:
- Host-driven command sequencer for the FrontPanel endpoint datapath.
- Wire-in endpoints supply an opcode and two 16-bit operands. A trigger-in pulse starts the command.
- The block runs the operation (single-cycle or multi-cycle), then posts a 32-bit result and a status word to wire-out endpoints.
- It serialises host commands onto one shared arithmetic datapath and reports busy, done and error conditions for the host to poll.

Parameters:
- CNT_W, 8, width of the accepted-command counter in status[15:8]; legal range 1..8, upper status bits zero when <8.
- MUL_EN, 1, 1 = MUL opcode supported; 0 = MUL treated as illegal.

Ports:
- ti_clk  input  1  host-interface clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- cmd_trig  input  1  one-cycle start pulse (from trigger-in).
- cmd_op  input  3  opcode, sampled with cmd_trig.
- op_a  input  16  operand A, sampled with cmd_trig.
- op_b  input  16  operand B, sampled with cmd_trig.
- cmd_ack  input  1  one-cycle pulse; clears done and error flags.
- result_lo  output  16  result[15:0] (to wire-out).
- result_hi  output  16  result[31:16] (to wire-out).
- status  output  16  {cmd_count, last_op(4b), illegal, overrun, done, busy} from bit 15 down to bit 0.
- done_pulse  output  1  one-cycle pulse on command completion (to trigger-out).

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE. result_lo, result_hi, status and done_pulse = 0. Accumulator = 0. cmd_count = 0.
- States: IDLE, EXEC, MULT, DONE.
- IDLE + cmd_trig:
  - Latch op/a/b and increment cmd_count (wraps at 2^CNT_W).
  - Set busy, clear done, set last_op = {1'b0, cmd_op}.
  - Next state is EXEC.
  - An illegal op (5..7, or 3 when MUL_EN=0) is still accepted and counted. In EXEC it sets sticky illegal, leaves result unchanged, and goes to DONE.
- Opcodes:
  - 0 NOP: result unchanged.
  - 1 ADD: result = {15'b0, a+b (17 bits)}.
  - 2 SUB: result_lo = (a-b) mod 2^16; result_hi = 16'hFFFF if a<b, else 0.
  - 3 MUL: unsigned 16x16 shift-add, one partial product per cycle, 16 cycles in MULT.
  - 4 ACC: acc = (acc + a) mod 2^32; result = new acc.
  - 5+: illegal.
- EXEC:
  - ADD/SUB/NOP/ACC: compute and register result, then go to DONE.
  - MUL: clear the product register, load the iteration counter with 15, go to MULT.
- MULT: each cycle, if b[i] is set, add (a<<i) to the product. Stay until the counter reaches 0, then write the result and go to DONE.
- DONE (one cycle):
  - done_pulse = 1, set done, clear busy, go to IDLE.
  - result_lo and result_hi update on the same edge that done_pulse asserts. They hold until the next command's completion.
- Latency, with trig sampled at edge T0:
  - Single-cycle ops: result and done_pulse visible after edge T0+2. Next trigger accepted at edge T0+3.
  - MUL: done_pulse after edge T0+18.
- cmd_trig while busy (EXEC/MULT/DONE): command dropped, not counted, sticky overrun set. The in-flight command is unaffected.
- cmd_ack: clears done, overrun and illegal on the next edge. It does not affect busy or results.
- cmd_ack and cmd_trig in the same cycle in IDLE: command accepted; flags cleared. done ends up 0 because accept also clears it.
- cmd_ack in the same cycle an error is raised: set wins (the flag remains 1).
- Reset mid-MULT: immediate abort. All outputs return to reset values; no done_pulse.
- status is a registered output, updated every cycle.

Test Plan:
- Reset, then ADD a=16'hFFFF b=16'h0001 -> after 2 cycles result_hi=16'h0001, result_lo=16'h0000, done_pulse for 1 cycle, status=16'h0112.
- SUB a=3 b=5 -> result_lo=16'hFFFE, result_hi=16'hFFFF. MUL a=16'hFFFF b=16'hFFFF -> result=32'hFFFE0001, done_pulse exactly 18 cycles after trig.
- MUL a=1234 b=0 started, cmd_trig again 4 cycles later -> overrun=1, cmd_count incremented once, result=0 after completion. cmd_ack -> overrun=0.
- ACC a=16'h8000 issued three times -> result 32'h00008000, then 32'h00010000, then 32'h00018000. Reset -> accumulator 0, status 0.
- cmd_op=6 -> illegal=1, result unchanged, done_pulse asserted, counter incremented. With MUL_EN=0, op 3 -> illegal=1.
- Assert reset during MULT at cycle 8 -> all outputs 0 asynchronously, no done_pulse. A subsequent ADD 2+3 -> result 5.
